// File: rtl/vx_wctl_mp_unit_pkg.sv
// Shared types and sizing for the multi-packet warp-control unit.
// Optional performance counters are enabled with the WCTL_PERF_EN macro.
package vx_wctl_mp_unit_pkg;

  function automatic int up(input int x);
    return (x > 0) ? x : 1;
  endfunction

  localparam int NUM_THREADS      = 4;
  localparam int NUM_WARPS        = 4;
  localparam int NW_BITS          = $clog2(NUM_WARPS);
  localparam int NW_WIDTH         = up(NW_BITS);
  localparam int XLEN             = 32;
  localparam int INST_SFU_BITS    = 4;
  localparam int NUM_BARRIERS_DEF = 4;
  localparam int NB_WIDTH         = up($clog2(NUM_BARRIERS_DEF));
  localparam int LANE_BITS        = $clog2(NUM_THREADS);
  localparam int PID_WIDTH        = up(LANE_BITS);

  typedef enum logic [INST_SFU_BITS-1:0] {
    SFU_TMC    = 4'd0,
    SFU_WSPAWN = 4'd1,
    SFU_SPLIT  = 4'd2,
    SFU_JOIN   = 4'd3,
    SFU_BAR    = 4'd4,
    SFU_PRED   = 4'd5
  } sfu_op_e;

  typedef struct packed {
    logic                   valid;
    logic [NUM_THREADS-1:0] tmask;
  } tmc_t;

  typedef struct packed {
    logic                 valid;
    logic [NUM_WARPS-1:0] wmask;
    logic [XLEN-1:0]      pc;
  } wspawn_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [XLEN-1:0]        next_pc;
  } split_t;

  typedef struct packed {
    logic valid;
    logic is_dvg;
  } join_t;

  typedef struct packed {
    logic                valid;
    logic [NB_WIDTH-1:0] id;
    logic [NW_WIDTH-1:0] size_m1;
  } barrier_t;

  typedef struct packed {
    tmc_t     tmc;
    wspawn_t  wspawn;
    split_t   split;
    join_t    sjoin;
    barrier_t barrier;
  } wctl_cmd_t;

endpackage

// File: rtl/vx_wctl_mp_unit_bar_table.sv
// Local barrier table: counts arrivals per id and emits a one-cycle release wmask.
// With WCTL_PERF_EN defined, also reports whether any barrier is partially filled.
module vx_wctl_mp_unit_bar_table
  import vx_wctl_mp_unit_pkg::*;
#(
  parameter int NUM_BARRIERS = NUM_BARRIERS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arr_valid,
  input  logic [NB_WIDTH-1:0]  arr_id,
  input  logic [NW_WIDTH-1:0]  arr_size_m1,
  input  logic [NW_WIDTH-1:0]  arr_wid,
  output logic                 rel_valid,
  output logic [NUM_WARPS-1:0] rel_wmask
`ifdef WCTL_PERF_EN
  ,
  output logic                 busy
`endif
);

  logic [NW_WIDTH-1:0]  count [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask [NUM_BARRIERS];

  logic                 id_ok;
  logic [NB_WIDTH-1:0]  idx;
  logic [NUM_WARPS-1:0] wid_bit;

  assign id_ok   = int'(arr_id) < NUM_BARRIERS;
  assign idx     = id_ok ? arr_id : '0;
  assign wid_bit = NUM_WARPS'(1) << arr_wid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_valid <= 1'b0;
      rel_wmask <= '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        count[b] <= '0;
        wmask[b] <= '0;
      end
    end else begin
      rel_valid <= 1'b0;
      // A warp already recorded at this barrier is a repeat arrival and is ignored.
      if (arr_valid && id_ok && !wmask[idx][arr_wid]) begin
        if (count[idx] == arr_size_m1) begin
          rel_valid  <= 1'b1;
          rel_wmask  <= wmask[idx] | wid_bit;
          count[idx] <= '0;
          wmask[idx] <= '0;
        end else begin
          if (count[idx] != NW_WIDTH'(NUM_WARPS - 1))
            count[idx] <= count[idx] + 1'b1;
          wmask[idx] <= wmask[idx] | wid_bit;
        end
      end
    end
  end

`ifdef WCTL_PERF_EN
  always_comb begin
    busy = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++)
      if (count[b] != '0) busy = 1'b1;
  end
`endif

endmodule

// File: rtl/vx_wctl_mp_unit.sv
// Multi-packet warp-control execute unit: per-warp split accumulators, buffered output.
// Defining WCTL_PERF_EN adds three wrapping 32-bit performance counters.
module vx_wctl_mp_unit
  import vx_wctl_mp_unit_pkg::*;
#(
  parameter int NUM_LANES    = 1,
  parameter int NUM_BARRIERS = NUM_BARRIERS_DEF,
  parameter int OUT_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NW_WIDTH-1:0]           in_wid,
  input  logic [INST_SFU_BITS-1:0]      in_op,
  input  logic [NUM_LANES-1:0]          in_tmask,
  input  logic [PID_WIDTH-1:0]          in_pid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [XLEN-1:0]               in_pc,
  input  logic [up(LANE_BITS)-1:0]      in_tid,
  input  logic [NUM_LANES*XLEN-1:0]     in_rs1,
  input  logic [NUM_LANES*XLEN-1:0]     in_rs2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NW_WIDTH-1:0]           out_wid,
  output logic [PID_WIDTH-1:0]          out_pid,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [NUM_LANES*XLEN-1:0]     out_data,
  output logic                          ctl_valid,
  output logic [NW_WIDTH-1:0]           ctl_wid,
  output logic [$bits(wctl_cmd_t)-1:0]  ctl_cmd,
  output logic                          bar_rel_valid,
  output logic [NUM_WARPS-1:0]          bar_rel_wmask
`ifdef WCTL_PERF_EN
  ,
  output logic [31:0]                   perf_split_dvg_o,
  output logic [31:0]                   perf_bar_wait_o,
  output logic [31:0]                   perf_stall_o
`endif
);

  localparam int PTR_W = up($clog2(OUT_DEPTH));
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [NW_WIDTH-1:0]  wid;
    logic [PID_WIDTH-1:0] pid;
    logic                 sop;
    logic                 eop;
    logic                 is_dvg;
    wctl_cmd_t            cmd;
  } entry_t;

  logic [NUM_THREADS-1:0] then_acc [NUM_WARPS];
  logic [NUM_THREADS-1:0] else_acc [NUM_WARPS];
  logic [NUM_THREADS-1:0] then_nxt, else_nxt;
  logic [NUM_LANES-1:0]   taken;
  logic [XLEN-1:0]        rs1_tid, rs2_tid, rs2_m1;
  wctl_cmd_t              cmd;
  entry_t                 in_entry, head;
  logic                   push, pop, full;

  assign rs1_tid = in_rs1[int'(in_tid)*XLEN +: XLEN];
  assign rs2_tid = in_rs2[int'(in_tid)*XLEN +: XLEN];
  assign rs2_m1  = rs2_tid - 1'b1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    then_nxt = in_sop ? '0 : then_acc[in_wid];
    else_nxt = in_sop ? '0 : else_acc[in_wid];
    for (int l = 0; l < NUM_LANES; l++) taken[l] = in_rs1[l*XLEN];
    then_nxt[int'(in_pid)*NUM_LANES +: NUM_LANES] = taken & in_tmask;
    else_nxt[int'(in_pid)*NUM_LANES +: NUM_LANES] = ~taken & in_tmask;

    cmd = '0;
    if (in_eop) begin
      case (sfu_op_e'(in_op))
        SFU_TMC: begin
          cmd.tmc.valid = 1'b1;
          cmd.tmc.tmask = rs1_tid[NUM_THREADS-1:0];
        end
        SFU_PRED: begin
          cmd.tmc.valid = 1'b1;
          cmd.tmc.tmask = (then_nxt != '0) ? then_nxt : rs2_tid[NUM_THREADS-1:0];
        end
        SFU_SPLIT: begin
          cmd.split.valid      = 1'b1;
          cmd.split.is_dvg     = (then_nxt != '0) && (else_nxt != '0);
          cmd.split.then_tmask = then_nxt;
          cmd.split.else_tmask = else_nxt;
          cmd.split.next_pc    = in_pc + XLEN'(4);
        end
        SFU_JOIN: begin
          cmd.sjoin.valid  = 1'b1;
          cmd.sjoin.is_dvg = rs1_tid[0];
        end
        SFU_WSPAWN: begin
          cmd.wspawn.valid = 1'b1;
          cmd.wspawn.pc    = rs2_tid;
          for (int w = 0; w < NUM_WARPS; w++)
            cmd.wspawn.wmask[w] = (w < int'(rs1_tid[NW_BITS:0])) && (w != int'(in_wid));
        end
        SFU_BAR: begin
          cmd.barrier.valid   = 1'b1;
          cmd.barrier.id      = rs1_tid[NB_WIDTH-1:0];
          cmd.barrier.size_m1 = rs2_m1[NW_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign in_entry = '{wid: in_wid, pid: in_pid, sop: in_sop, eop: in_eop,
                      is_dvg: cmd.split.is_dvg, cmd: cmd};

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        then_acc[w] <= '0;
        else_acc[w] <= '0;
      end
    end else if (push) begin
      then_acc[in_wid] <= then_nxt;
      else_acc[in_wid] <= else_nxt;
    end
  end

  // Output elastic buffer: a full buffer refuses input even while draining.
  entry_t            mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign full      = (count == CNT_W'(OUT_DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign head      = mem[rd_ptr];

  // NOTE: payload storage has no reset; the cleared count already marks every slot empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign out_wid   = head.wid;
  assign out_pid   = head.pid;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;
  assign ctl_valid = pop && head.eop;
  assign ctl_wid   = head.wid;
  assign ctl_cmd   = head.cmd;

  always_comb begin
    out_data = '0;
    for (int l = 0; l < NUM_LANES; l++) out_data[l*XLEN] = head.is_dvg;
  end

`ifdef WCTL_PERF_EN
  logic bar_busy;
`endif

  vx_wctl_mp_unit_bar_table #(
    .NUM_BARRIERS (NUM_BARRIERS)
  ) u_bar_table (
    .clk         (clk),
    .reset       (reset),
    .arr_valid   (ctl_valid && head.cmd.barrier.valid),
    .arr_id      (head.cmd.barrier.id),
    .arr_size_m1 (head.cmd.barrier.size_m1),
    .arr_wid     (head.wid),
    .rel_valid   (bar_rel_valid),
    .rel_wmask   (bar_rel_wmask)
`ifdef WCTL_PERF_EN
    ,
    .busy        (bar_busy)
`endif
  );

`ifdef WCTL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_split_dvg_o <= '0;
      perf_bar_wait_o  <= '0;
      perf_stall_o     <= '0;
    end else begin
      if (ctl_valid && head.cmd.split.valid && head.cmd.split.is_dvg)
        perf_split_dvg_o <= perf_split_dvg_o + 1'b1;
      if (bar_busy)
        perf_bar_wait_o <= perf_bar_wait_o + 1'b1;
      if (in_valid && !in_ready)
        perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_wctl_mp_unit.sv
// Scoreboard bench for vx_wctl_mp_unit with two lanes per packet and two barriers.
module tb_vx_wctl_mp_unit;
  import vx_wctl_mp_unit_pkg::*;

  localparam int NL = 2;
  localparam int NB = 2;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         in_valid, in_ready;
  logic [NW_WIDTH-1:0]          in_wid;
  logic [INST_SFU_BITS-1:0]     in_op;
  logic [NL-1:0]                in_tmask;
  logic [PID_WIDTH-1:0]         in_pid;
  logic                         in_sop, in_eop;
  logic [XLEN-1:0]              in_pc;
  logic [up(LANE_BITS)-1:0]     in_tid;
  logic [NL*XLEN-1:0]           in_rs1, in_rs2;
  logic                         out_valid, out_ready;
  logic [NW_WIDTH-1:0]          out_wid;
  logic [PID_WIDTH-1:0]         out_pid;
  logic                         out_sop, out_eop;
  logic [NL*XLEN-1:0]           out_data;
  logic                         ctl_valid;
  logic [NW_WIDTH-1:0]          ctl_wid;
  logic [$bits(wctl_cmd_t)-1:0] ctl_cmd;
  logic                         bar_rel_valid;
  logic [NUM_WARPS-1:0]         bar_rel_wmask;
`ifdef WCTL_PERF_EN
  logic [31:0] perf_split_dvg_o, perf_bar_wait_o, perf_stall_o;
`endif

  vx_wctl_mp_unit #(.NUM_LANES(NL), .NUM_BARRIERS(NB), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_op(in_op),
    .in_tmask(in_tmask), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
    .in_pc(in_pc), .in_tid(in_tid), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .ctl_valid(ctl_valid), .ctl_wid(ctl_wid), .ctl_cmd(ctl_cmd),
    .bar_rel_valid(bar_rel_valid), .bar_rel_wmask(bar_rel_wmask)
`ifdef WCTL_PERF_EN
    , .perf_split_dvg_o(perf_split_dvg_o), .perf_bar_wait_o(perf_bar_wait_o),
    .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW_WIDTH-1:0]  wid;
    logic [PID_WIDTH-1:0] pid;
    logic                 sop, eop;
    logic [NL*XLEN-1:0]   data;
    wctl_cmd_t            cmd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference barrier state driven by the commands the scoreboard expects.
  logic [NW_WIDTH-1:0]  bm_cnt [NB];
  logic [NUM_WARPS-1:0] bm_msk [NB];
  logic                 exp_rel;
  logic [NUM_WARPS-1:0] exp_rel_mask;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic wctl_cmd_t mk_split(input logic [3:0] th, input logic [3:0] el,
                                         input logic dvg, input logic [31:0] npc);
    mk_split = '0;
    mk_split.split = '{valid: 1'b1, is_dvg: dvg, then_tmask: th, else_tmask: el, next_pc: npc};
  endfunction

  function automatic wctl_cmd_t mk_tmc(input logic [3:0] tm);
    mk_tmc = '0;
    mk_tmc.tmc = '{valid: 1'b1, tmask: tm};
  endfunction

  function automatic wctl_cmd_t mk_join(input logic dvg);
    mk_join = '0;
    mk_join.sjoin = '{valid: 1'b1, is_dvg: dvg};
  endfunction

  function automatic wctl_cmd_t mk_wspawn(input logic [3:0] wm, input logic [31:0] pc);
    mk_wspawn = '0;
    mk_wspawn.wspawn = '{valid: 1'b1, wmask: wm, pc: pc};
  endfunction

  function automatic wctl_cmd_t mk_bar(input logic [1:0] id, input logic [1:0] sm1);
    mk_bar = '0;
    mk_bar.barrier = '{valid: 1'b1, id: id, size_m1: sm1};
  endfunction

  task automatic send(input logic [1:0] wid, input logic [3:0] op, input logic [1:0] tmask,
                      input logic [1:0] pid, input logic sop, input logic eop,
                      input logic [31:0] pc, input logic [1:0] tid,
                      input logic [63:0] rs1, input logic [63:0] rs2,
                      input wctl_cmd_t ecmd, input logic edvg);
    exp_t e;
    bit   rdy;
    bit   done = 0;
    in_valid = 1'b1; in_wid = wid; in_op = op; in_tmask = tmask; in_pid = pid;
    in_sop = sop; in_eop = eop; in_pc = pc; in_tid = tid; in_rs1 = rs1; in_rs2 = rs2;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) done = 1;
    end
    if (done) begin
      e.wid = wid; e.pid = pid; e.sop = sop; e.eop = eop;
      e.data = edvg ? {32'd1, 32'd1} : '0;
      e.cmd  = ecmd;
      sb.push_back(e);
    end else begin
      check("accept_timeout", 0, 1);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_rel = 1'b0;
      for (int b = 0; b < NB; b++) begin bm_cnt[b] = '0; bm_msk[b] = '0; end
    end else begin
      if (exp_rel || bar_rel_valid) begin
        check("bar_rel_valid", bar_rel_valid, exp_rel);
        if (exp_rel) check("bar_rel_wmask", bar_rel_wmask, exp_rel_mask);
      end
      exp_rel = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_wid", out_wid, e.wid);
          check("out_pid", out_pid, e.pid);
          check("out_sop", out_sop, e.sop);
          check("out_eop", out_eop, e.eop);
          check("out_data", out_data, e.data);
          check("ctl_valid", ctl_valid, e.eop);
          if (e.eop) begin
            check("ctl_wid", ctl_wid, e.wid);
            check("ctl_cmd", ctl_cmd, e.cmd);
            if (e.cmd.barrier.valid && int'(e.cmd.barrier.id) < NB) begin
              int id;
              id = int'(e.cmd.barrier.id);
              if (!bm_msk[id][e.wid]) begin
                if (bm_cnt[id] == e.cmd.barrier.size_m1) begin
                  exp_rel      = 1'b1;
                  exp_rel_mask = bm_msk[id] | (4'b1 << e.wid);
                  bm_cnt[id]   = '0;
                  bm_msk[id]   = '0;
                end else begin
                  if (bm_cnt[id] != 2'd3) bm_cnt[id] = bm_cnt[id] + 1'b1;
                  bm_msk[id] = bm_msk[id] | (4'b1 << e.wid);
                end
              end
            end
          end
        end
      end else if (ctl_valid) begin
        check("ctl_spurious", ctl_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_wid = '0; in_op = '0; in_tmask = '0; in_pid = '0; in_sop = 1'b0; in_eop = 1'b0;
    in_pc = '0; in_tid = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_ctl_valid", ctl_valid, 0);
    check("rst_bar_rel", bar_rel_valid, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-packet SPLIT: then=1001 else=0110
    send(0, SFU_SPLIT, 2'b11, 0, 1, 0, 32'h100, 0, {32'd0, 32'd1}, '0, '0, 0);
    send(0, SFU_SPLIT, 2'b11, 1, 0, 1, 32'h100, 0, {32'd1, 32'd0}, '0,
         mk_split(4'b1001, 4'b0110, 1, 32'h104), 1);

    // Interleaved packets from warps 0 and 1
    send(0, SFU_SPLIT, 2'b11, 0, 1, 0, 32'h300, 0, {32'd1, 32'd1}, '0, '0, 0);
    send(1, SFU_SPLIT, 2'b11, 0, 1, 0, 32'h200, 0, {32'd0, 32'd0}, '0, '0, 0);
    send(1, SFU_SPLIT, 2'b01, 1, 0, 1, 32'h200, 0, {32'd0, 32'd1}, '0,
         mk_split(4'b0100, 4'b0011, 1, 32'h204), 1);
    send(0, SFU_SPLIT, 2'b11, 1, 0, 1, 32'h300, 0, {32'd0, 32'd0}, '0,
         mk_split(4'b0011, 4'b1100, 1, 32'h304), 1);

    // PRED with no taken lanes falls back to rs2[tid]; then TMC and JOIN
    send(2, SFU_PRED, 2'b11, 0, 1, 0, 32'h0, 1, '0, '0, '0, 0);
    send(2, SFU_PRED, 2'b11, 1, 0, 1, 32'h0, 1, '0, {32'hA, 32'h0}, mk_tmc(4'b1010), 0);
    send(3, SFU_TMC, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'h5}, '0, mk_tmc(4'b0101), 0);
    send(1, SFU_JOIN, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'h1}, '0, mk_join(1), 0);

    // WSPAWN rs1=3 from warp 1
    send(1, SFU_WSPAWN, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd3}, {32'd0, 32'h8000},
         mk_wspawn(4'b0101, 32'h8000), 0);

    // Barrier 1 of size 3, then single-warp barrier, then an out-of-range id
    send(0, SFU_BAR, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd1}, {32'd0, 32'd3}, mk_bar(1, 2), 0);
    send(2, SFU_BAR, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd1}, {32'd0, 32'd3}, mk_bar(1, 2), 0);
    send(3, SFU_BAR, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd1}, {32'd0, 32'd3}, mk_bar(1, 2), 0);
    send(1, SFU_BAR, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd1}, {32'd0, 32'd1}, mk_bar(1, 0), 0);
    send(0, SFU_BAR, 2'b11, 0, 1, 1, 32'h0, 0, {32'd0, 32'd3}, {32'd0, 32'd1}, mk_bar(3, 0), 0);
    drain();
    repeat (3) @(negedge clk);

    // Back-pressure: two accepts fill the buffer, head holds
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3, SFU_TMC, 2'b11, 0, 1, 0, 32'h0, 0, '0, '0, '0, 0);
    send(3, SFU_TMC, 2'b11, 1, 0, 1, 32'h0, 1, {32'hF, 32'h0}, '0, mk_tmc(4'b1111), 0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    repeat (5) @(negedge clk);
    check("bp_in_ready_hold", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_pid", out_pid, 0);
    check("bp_head_sop", out_sop, 1);
    fork
      send(0, SFU_JOIN, 2'b11, 0, 1, 1, 32'h0, 0, '0, '0, mk_join(0), 0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a two-packet instruction
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(2, SFU_SPLIT, 2'b11, 0, 1, 0, 32'h400, 0, {32'd1, 32'd1}, '0, '0, 0);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ctl_valid", ctl_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(2, SFU_SPLIT, 2'b11, 0, 1, 0, 32'h400, 0, {32'd0, 32'd1}, '0, '0, 0);
    send(2, SFU_SPLIT, 2'b11, 1, 0, 1, 32'h400, 0, {32'd0, 32'd0}, '0,
         mk_split(4'b0001, 4'b1110, 1, 32'h404), 1);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vx_wctl_mp_unit.md
Name: VX_wctl_mp_unit

Overview:
- Multi-packet warp-control execute unit in the SFU path. It decodes TMC, PRED, SPLIT, JOIN, BAR and WSPAWN and issues warp-control commands to the scheduler.
- Generalises the single-context design:
  - per-warp then/else mask accumulators, so partial packets (pid) from different warps may interleave;
  - a local barrier table that counts arrivals itself and emits a release wmask, so the scheduler does not need a counter;
  - configurable output buffering.

Parameters:
- NUM_LANES, 1: lanes per packet; must divide `NUM_THREADS.
- NUM_BARRIERS, `NUM_BARRIERS: local barrier table entries.
- OUT_DEPTH, 2: output elastic-buffer depth, ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid/in_ready  in/out  1/1  execute handshake
- in_wid  in  `NW_WIDTH  warp id
- in_op  in  `INST_SFU_BITS  SFU op type
- in_tmask  in  NUM_LANES  packet lane mask
- in_pid  in  PID_WIDTH  packet index
- in_sop/in_eop  in  1/1  first/last packet of the instruction
- in_pc  in  `XLEN  instruction PC
- in_tid  in  `UP(LANE_BITS)  leader lane
- in_rs1/in_rs2  in  NUM_LANES*`XLEN  operands
- out_valid/out_ready  out/in  1/1  commit handshake; one beat per packet
- out_wid, out_pid, out_sop, out_eop  out  passthrough of the input fields
- out_data  out  NUM_LANES*`XLEN  each lane carries is_dvg of SPLIT, else 0
- ctl_valid  out  1  warp-control command strobe
- ctl_wid  out  `NW_WIDTH  target warp
- ctl_cmd  out  $bits(wctl_cmd_t)  packed command, see the package
- bar_rel_valid  out  1  barrier release strobe
- bar_rel_wmask  out  `NUM_WARPS  warps to release

Behaviour:
- Reset (async, active-high): out_valid=0, ctl_valid=0, bar_rel_valid=0.
  - All accumulators, barrier counters, barrier wmasks and buffer pointers are cleared to 0.
  - Any in-flight multi-packet instruction is discarded.
- in_ready = output buffer not full. A packet is accepted when in_valid&&in_ready.
- Accumulators, indexed by in_wid:
  - taken[i] = rs1[i][0].
  - If sop, the slice outside the current packet clears to 0.
  - The slice [pid*NUM_LANES +: NUM_LANES] is written with taken&tmask (then) and ~taken&tmask (else).
  - The merged value (next-state) is used when eop is set in the same cycle.
  - Other warps' accumulators are untouched.
- Command fields are computed only on eop packets:
  - TMC: tmask = rs1[tid][NT-1:0].
  - PRED: tmask = then≠0 ? then : rs2[tid].
  - SPLIT: is_dvg = then≠0 && else≠0; next_pc = pc+4.
  - JOIN: is_dvg = rs1[tid][0].
  - WSPAWN: wmask[i] = i<rs1[tid][`NW_BITS:0] && i≠wid; pc = rs2[tid].
  - BAR: id = rs1[tid][`NB_WIDTH-1:0]; size_m1 = rs2[tid]-1, truncated to the field width.
- Latency:
  - Command and packet fields enter the buffer on accept. The output appears ≥1 cycle later (registered buffer).
  - ctl_valid = out_valid && out_ready && out_eop, with ctl_cmd taken from the buffer head.
- Barrier table, updated on a BAR command at the ctl_valid cycle:
  - If count[id]==size_m1: bar_rel_valid=1 the next cycle; bar_rel_wmask = wmask[id] | (1<<wid); count and wmask of that id clear to 0.
  - Otherwise count[id]++ and wmask[id] |= 1<<wid.
  - size_m1=0 releases immediately: a single-warp barrier.
  - The count saturates at `NUM_WARPS-1. A repeat arrival by a warp already in the mask does not increment.
  - A release and a new arrival on the same id cannot coincide; updates are serialised by ctl_valid.
  - Barriers with id≥NUM_BARRIERS are ignored and produce no release.
  - bar_rel_valid is a 1-cycle pulse.
- Output buffer:
  - Empty: out_valid=0.
  - Full: in_ready=0 and no accumulator update. Back-pressure holds the head stable.
  - Simultaneous push and pop on a full buffer is allowed only when OUT_DEPTH>1 and a skid slot exists. Otherwise in_ready stays 0.

Optional Feature:
- Macro: WCTL_PERF_EN.
- With the macro defined, three 32-bit counters are present, all reset to 0 and wrapping:
  - perf_split_dvg_o: counts divergent SPLITs;
  - perf_bar_wait_o: counts cycles in which any barrier count is nonzero;
  - perf_stall_o: counts cycles with in_valid && !in_ready.
- Without the macro, these ports and counters do not exist.

Decomposition:
- VX_gpu_pkg holds:
  - the existing tmc_t, wspawn_t, split_t, join_t and barrier_t types;
  - a new packed wctl_cmd_t that bundles those five types;
  - the localparams PID_WIDTH and LANE_BITS.
- One natural sub-module: VX_wctl_bar_table (counters, wmask, release logic).
- The buffer reuses VX_elastic_buffer.

Test Plan:
- NUM_LANES=2, NT=4, SPLIT with rs1 lane bits 1,0 | 0,1 over 2 packets, tmask all-1 -> then=0b1001, else=0b0110, is_dvg=1, ctl_valid once with next_pc=pc+4.
- Interleave: warp0 pid0, warp1 pid0, warp1 pid1 (eop), warp0 pid1 (eop) -> each warp's masks are independent and match its non-interleaved result.
- BAR id=1 size=3: warps 0,2,3 arrive -> no release for the first two; the third arrival gives bar_rel_wmask=0b1101 one cycle later, and count clears.
- out_ready=0 for 5 cycles with OUT_DEPTH=2 -> in_ready falls after 2 accepts, no data lost, ctl_valid only on the eop pop.
- Reset asserted mid-instruction (after pid0, before eop) -> out_valid=0 immediately. A fresh sop instruction afterwards produces clean masks.
- WSPAWN rs1=3 from wid=1, NW=4 -> wmask=0b0101, pc=rs2.
